// File: rtl/seg7_pkg.sv
// Shared types and constants for the 8-digit seven-segment scan driver.
// The hex decode table lives here so the decoder and any checker use one source.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-high segments, bit6 = g ... bit0 = a
    function automatic logic [6:0] hex_to_seg(input logic [3:0] i_hex);
        logic [6:0] seg;
        case (i_hex)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b1011000;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display data in, anode/cathode drive out. There is no valid/ready handshake:
// the slave samples the data inputs once per frame and the outputs are free-running.
interface seg7_scan_driver_if;
    import seg7_pkg::*;

    logic [31:0] data94;
    logic [7:0]  digit_en94;
    logic [7:0]  dp94;
    logic        lz_en94;
    logic [7:0]  an94;
    logic [6:0]  ssg94;
    logic        dp_out94;
    logic        frame_tick94;
    state_t      dbg_state;

    modport master (
        output data94, digit_en94, dp94, lz_en94,
        input  an94, ssg94, dp_out94, frame_tick94, dbg_state
    );

    modport slave (
        input  data94, digit_en94, dp94, lz_en94,
        output an94, ssg94, dp_out94, frame_tick94, dbg_state
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to active-high seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_hex);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode driver with per-slot blanking,
// leading-zero suppression and a once-per-frame input snapshot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV_BITS     = 17,
    parameter int BLANK_CYCLES = 64
) (
    input  logic mclk94,
    input  logic rst94,
    seg7_scan_driver_if.slave bus
);

    localparam logic [DIV_BITS-1:0] BLANK_L = DIV_BITS'(BLANK_CYCLES);

    logic [DIV_BITS-1:0] r_div;
    logic [2:0]          r_idx;
    state_t              r_state;
    logic [31:0]         r_data_sh;
    logic [7:0]          r_en_sh;
    logic [7:0]          r_dp_sh;
    logic                r_lz_sh;
    logic [7:0]          r_an;
    logic [6:0]          r_ssg;
    logic                r_dp;
    logic                r_tick;

    logic [DIV_BITS-1:0] w_div_next;
    logic                w_wrap;
    logic                w_snap;
    logic [3:0]          w_nibble;
    logic                w_upper_zero;
    logic                w_suppress;
    logic                w_visible;
    logic [6:0]          w_seg;

    assign w_div_next   = r_div + 1'b1;
    assign w_wrap       = &r_div;
    assign w_snap       = (r_idx == 3'd0) && (r_div == '0);
    assign w_nibble     = r_data_sh[{r_idx, 2'b00} +: 4];
    // Nibbles idx..7 all zero means this digit is a leading zero
    assign w_upper_zero = ((r_data_sh >> {r_idx, 2'b00}) == 32'd0);
    assign w_suppress   = r_lz_sh && (r_idx != 3'd0) && w_upper_zero;
    assign w_visible    = (r_state == SHOW) && r_en_sh[r_idx] && !w_suppress;

    hex_to_seg7 u_dec (
        .i_hex (w_nibble),
        .o_seg (w_seg)
    );

    always_ff @(posedge mclk94 or posedge rst94) begin
        if (rst94) begin
            r_div     <= '0;
            r_idx     <= 3'd0;
            r_state   <= BLANK;
            r_data_sh <= 32'd0;
            r_en_sh   <= 8'd0;
            r_dp_sh   <= 8'd0;
            r_lz_sh   <= 1'b0;
            r_an      <= AN_OFF;
            r_ssg     <= SEG_OFF;
            r_dp      <= 1'b1;
            r_tick    <= 1'b0;
        end else begin
            r_div <= w_div_next;
            if (w_wrap) r_idx <= r_idx + 3'd1;

            case (r_state)
                BLANK:   if (w_div_next >= BLANK_L) r_state <= SHOW;
                SHOW:    if (w_wrap && (BLANK_L != '0)) r_state <= BLANK;
                default: r_state <= BLANK;
            endcase

            if (w_snap) begin
                r_data_sh <= bus.data94;
                r_en_sh   <= bus.digit_en94;
                r_dp_sh   <= bus.dp94;
                r_lz_sh   <= bus.lz_en94;
            end
            r_tick <= w_snap;

            // Registering the drive keeps anode switching glitch-free
            r_an  <= w_visible ? ~(8'b1 << r_idx) : AN_OFF;
            r_ssg <= w_visible ? ~w_seg : SEG_OFF;
            r_dp  <= w_visible ? ~r_dp_sh[r_idx] : 1'b1;
        end
    end

    assign bus.an94         = r_an;
    assign bus.ssg94        = r_ssg;
    assign bus.dp_out94     = r_dp;
    assign bus.frame_tick94 = r_tick;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 16-cycle slots, 2 blank cycles.
module tb_seg7_scan_driver;

    localparam int DIV_BITS     = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int SLOT         = 16;
    localparam int FRAME        = 128;

    // Expected active-low cathodes per hex value, bit6 = g ... bit0 = a
    localparam logic [6:0] SEG_LOW [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic mclk94 = 1'b0;
    logic rst94  = 1'b1;

    seg7_scan_driver_if u_if ();

    seg7_scan_driver #(
        .DIV_BITS     (DIV_BITS),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_dut (
        .mclk94 (mclk94),
        .rst94  (rst94),
        .bus    (u_if)
    );

    // clock / reset
    always #5 mclk94 = ~mclk94;

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;

    logic [31:0] m_data;
    logic [7:0]  m_en;
    logic [7:0]  m_dp;
    logic        m_lz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at n=%0d: got %h expected %h", tag, n, got, exp);
        end
    endtask

    // {an, ssg, dp, tick} expected after n clock edges since reset release
    function automatic logic [16:0] model_out(input int nn);
        int m, dv, ix;
        logic vis;
        logic [7:0] an_e;
        logic [6:0] ssg_e;
        logic dp_e;
        logic tick_e;
        if (nn == 0) return {8'hFF, 7'h7F, 1'b1, 1'b0};
        m      = nn - 1;
        dv     = m % SLOT;
        ix     = (m / SLOT) % 8;
        tick_e = ((nn % FRAME) == 1);
        vis    = (dv >= BLANK_CYCLES) && m_en[ix]
                 && !(m_lz && (ix > 0) && ((m_data >> (4 * ix)) == 32'd0));
        an_e  = 8'hFF;
        ssg_e = 7'h7F;
        dp_e  = 1'b1;
        if (vis) begin
            an_e[ix] = 1'b0;
            ssg_e    = SEG_LOW[m_data[4*ix +: 4]];
            dp_e     = ~m_dp[ix];
        end
        return {an_e, ssg_e, dp_e, tick_e};
    endfunction

    // driver tasks
    task automatic step();
        if ((n % FRAME) == 0) begin
            m_data = u_if.data94;
            m_en   = u_if.digit_en94;
            m_dp   = u_if.dp94;
            m_lz   = u_if.lz_en94;
        end
        @(posedge mclk94);
        n++;
        @(negedge mclk94);
        check("cycle", {15'd0, u_if.an94, u_if.ssg94, u_if.dp_out94, u_if.frame_tick94},
              {15'd0, model_out(n)});
        check("onehot", {31'd0, ($countones(~u_if.an94) <= 1)}, 32'd1);
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic spot(input string tag, input logic [7:0] an_e, input logic [6:0] ssg_e,
                        input logic dp_e);
        check({tag, "_an"}, {24'd0, u_if.an94}, {24'd0, an_e});
        check({tag, "_ssg"}, {25'd0, u_if.ssg94}, {25'd0, ssg_e});
        check({tag, "_dp"}, {31'd0, u_if.dp_out94}, {31'd0, dp_e});
    endtask

    task automatic check_reset_vals(input string tag);
        spot(tag, 8'hFF, 7'h7F, 1'b1);
        check({tag, "_tick"}, {31'd0, u_if.frame_tick94}, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge mclk94);
        rst94 = 1'b0;
        n = 0;
        check_reset_vals("rel");
    endtask

    initial begin
        u_if.data94     = 32'h76543210;
        u_if.digit_en94 = 8'hFF;
        u_if.dp94       = 8'h00;
        u_if.lz_en94    = 1'b0;
        m_data = '0; m_en = '0; m_dp = '0; m_lz = 1'b0;
        repeat (3) @(negedge mclk94);
        check_reset_vals("por");
        release_reset();

        step();
        check("tick_first", {31'd0, u_if.frame_tick94}, 32'd1);

        // plain scan of 76543210
        run_to(49);  spot("s3_blank0", 8'hFF, 7'h7F, 1'b1);
        run_to(50);  spot("s3_blank1", 8'hFF, 7'h7F, 1'b1);
        run_to(55);  spot("s3_show", 8'hF7, 7'b0110000, 1'b1);

        // mid-frame data change must not tear
        run_to(70);  u_if.data94 = 32'hFFFFFFFF;
        run_to(100); spot("s6_old", 8'hBF, 7'b0000010, 1'b1);
        run_to(200); spot("s4_new", 8'hEF, 7'b0001110, 1'b1);

        // asynchronous reset in the middle of slot 5
        run_to(344); spot("s5_pre", 8'hDF, 7'b0001110, 1'b1);
        rst94 = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        u_if.data94     = 32'h00000A05;
        u_if.digit_en94 = 8'hFF;
        u_if.dp94       = 8'h00;
        u_if.lz_en94    = 1'b1;
        release_reset();

        // leading-zero suppression on 00000A05
        run_to(8);   spot("lz_d0", 8'hFE, 7'b0010010, 1'b1);
        run_to(24);  spot("lz_d1", 8'hFD, 7'b1000000, 1'b1);
        run_to(40);  spot("lz_d2", 8'hFB, 7'b0001000, 1'b1);
        run_to(60);  spot("lz_d3", 8'hFF, 7'h7F, 1'b1);
        run_to(120); spot("lz_d7", 8'hFF, 7'h7F, 1'b1);

        // digit enables and decimal point
        u_if.data94     = 32'h76543210;
        u_if.digit_en94 = 8'h0F;
        u_if.dp94       = 8'h01;
        u_if.lz_en94    = 1'b0;
        run_to(130); spot("dp_blank", 8'hFF, 7'h7F, 1'b1);
        run_to(136); spot("dp_d0", 8'hFE, 7'b1000000, 1'b0);
        run_to(152); spot("dp_d1", 8'hFD, 7'b1111001, 1'b1);
        run_to(216); spot("en_d5", 8'hFF, 7'h7F, 1'b1);
        run_to(248); spot("en_d7", 8'hFF, 7'h7F, 1'b1);

        // all-zero data with suppression, frame tick period
        u_if.data94     = 32'h0;
        u_if.digit_en94 = 8'hFF;
        u_if.dp94       = 8'h00;
        u_if.lz_en94    = 1'b1;
        run_to(257); check("tick_f2", {31'd0, u_if.frame_tick94}, 32'd1);
        run_to(264); spot("z_d0", 8'hFE, 7'b1000000, 1'b1);
        run_to(280); spot("z_d1", 8'hFF, 7'h7F, 1'b1);
        run_to(384); check("tick_pre", {31'd0, u_if.frame_tick94}, 32'd0);
        run_to(385); check("tick_f3", {31'd0, u_if.frame_tick94}, 32'd1);
        run_to(520);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
